test_byte_mux: RTL and testbench
================================

// Module: test_byte_mux
// PURPOSE
//   Parameterised M-to-1 lane multiplexer with a registered output. It selects one
//   N-bit lane from a packed N*M-bit input word using i_sel. It sits in datapaths
//   that extract one byte (or lane) from a wide bus, e.g. 64-bit word -> 8-bit byte.
//   One clock; reset is asynchronous and active-low.
// PARAMETERS
//   N   8  lane width in bits
//   M   8  number of lanes; i_data is N*M bits wide
//   SW  4  width of i_sel; must satisfy 2**SW >= M
// PORTS
//   i_clk     in   1    clock, rising edge
//   i_rst_n   in   1    asynchronous active-low reset
//   i_data    in   N*M  packed lanes; lane k = i_data[k*N +: N]
//   i_sel     in   SW   lane index, 0..M-1 valid
//   o_data    out  N    selected lane, registered
//   o_sel_err out  1    registered flag: previous-cycle i_sel >= M
// BEHAVIOUR
//   - Reset: while i_rst_n=0, o_data=0 and o_sel_err=0 immediately (async assert).
//     Deassertion takes effect at the next rising i_clk edge.
//   - Each rising edge with i_sel<M: o_data <= i_data[i_sel*N +: N] and o_sel_err <= 0.
//   - Each rising edge with i_sel>=M (SW-wide compare): o_data <= 0 and o_sel_err <= 1.
//   - Latency is exactly 1 cycle from i_data/i_sel to o_data. There is no handshake;
//     inputs are sampled every cycle.
//   - Lane 0 is the least significant N bits. Lane M-1 is the most significant.
//   - i_sel bits above those needed for M still take part in the range check.
//     No wrap-around or truncation: sel=8 with M=8 is an error, not lane 0.
//   - Reset asserted mid-operation clears both outputs at once. The first valid
//     output appears one edge after reset release.
//   - No X propagation. All outputs are driven from flops.
// CONFIGURATION
//   TEST_BYTE_MUX_PARITY_EN
//     Defined: extra output port o_parity (out, 1), registered with o_data.
//       o_parity = ^selected lane (even parity, XOR of the N bits).
//       o_parity = 0 on a reset or sel-error cycle.
//     Undefined: port o_parity and its logic are absent.
//       Every other behaviour is identical.
// STRUCTURE
//   - Package test_byte_mux_pkg holds:
//     - default constants LANE_W=8, LANE_CNT=8, SEL_W=4
//     - a function lane_sel(data, sel) returning the indexed lane
//   - Sub-module test_byte_mux_lane_sel: purely combinational lane extractor plus
//     range check, outputs lane and err.
//   - The top level adds the output register stage and the optional parity logic.
// TESTING
//   - Reset: hold i_rst_n=0, drive i_data=64'hABCD_EFAB_CDEF_ABCD, i_sel=3.
//     -> o_data=8'h00, o_sel_err=0 while in reset.
//   - Sweep: i_data=64'hABCD_EFAB_CDEF_ABCD, i_sel=0..7, one value per cycle.
//     -> one cycle later o_data = CD, AB, EF, CD, AB, EF, CD, AB; o_sel_err=0.
//   - Out of range: i_sel=4'd8 and then 4'd15.
//     -> o_data=8'h00 and o_sel_err=1 for each; i_sel=2 next -> o_data=8'hEF, o_sel_err=0.
//   - Async reset mid-stream: with i_sel=1 (o_data=8'hAB), pulse i_rst_n low between
//     clock edges. -> o_data=0 before the next edge; 8'hAB returns one edge after release.
//   - Data change, constant select: i_sel=7, i_data 64'hABCD... -> 64'h1200_0000_0000_0000.
//     -> o_data goes 8'hAB -> 8'h12 with exactly 1-cycle lag.
//   - TEST_BYTE_MUX_PARITY_EN defined: select 8'hAB (5 ones) -> o_parity=1;
//     select 8'hCD (5 ones) -> o_parity=1; select 8'h12 (2 ones) -> o_parity=0.

Source files
------------

// File: rtl/test_byte_mux_pkg.sv
// Shared defaults and a lane-extract helper for the test_byte_mux lane multiplexer.
// The optional parity output is enabled by defining TEST_BYTE_MUX_PARITY_EN.
package test_byte_mux_pkg;

  localparam int LANE_W   = 8;
  localparam int LANE_CNT = 8;
  localparam int SEL_W    = 4;

  // Returns the selected lane at the default geometry; out-of-range selects give zero.
  function automatic logic [LANE_W-1:0] lane_sel(
    input logic [LANE_W*LANE_CNT-1:0] data,
    input logic [SEL_W-1:0]           sel
  );
    logic [LANE_W-1:0] lane;
    lane = '0;
    for (int k = 0; k < LANE_CNT; k++) begin
      if (sel == SEL_W'(k)) lane = data[k*LANE_W +: LANE_W];
    end
    return lane;
  endfunction

endpackage

// File: rtl/test_byte_mux_lane_sel.sv
// Combinational lane extractor with range check; an out-of-range select yields
// a zero lane and raises err.
module test_byte_mux_lane_sel
  import test_byte_mux_pkg::*;
#(
  parameter int N  = LANE_W,
  parameter int M  = LANE_CNT,
  parameter int SW = SEL_W
) (
  input  logic [N*M-1:0] data,
  input  logic [SW-1:0]  sel,
  output logic [N-1:0]   lane,
  output logic           err
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lane = '0;
    // Full-width compare: with M == 2**SW a truncated SW'(M) would wrap to zero.
    err  = (int'(sel) >= M);
    for (int k = 0; k < M; k++) begin
      if (sel == SW'(k)) lane = data[k*N +: N];
    end
  end

endmodule

// File: rtl/test_byte_mux.sv
// Registered M-to-1 lane multiplexer. Define TEST_BYTE_MUX_PARITY_EN to add
// o_parity, the even parity of the selected lane, registered alongside o_data.
module test_byte_mux
  import test_byte_mux_pkg::*;
#(
  parameter int N  = LANE_W,
  parameter int M  = LANE_CNT,
  parameter int SW = SEL_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N*M-1:0] i_data,
  input  logic [SW-1:0]  i_sel,
  output logic [N-1:0]   o_data,
  output logic           o_sel_err
`ifdef TEST_BYTE_MUX_PARITY_EN
  ,
  output logic           o_parity
`endif
);

  logic [N-1:0] lane;
  logic         err;

  test_byte_mux_lane_sel #(
    .N  (N),
    .M  (M),
    .SW (SW)
  ) u_lane_sel (
    .data (i_data),
    .sel  (i_sel),
    .lane (lane),
    .err  (err)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data    <= '0;
      o_sel_err <= 1'b0;
    end else begin
      o_data    <= err ? '0 : lane;
      o_sel_err <= err;
    end
  end

`ifdef TEST_BYTE_MUX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_parity <= 1'b0;
    end else begin
      o_parity <= err ? 1'b0 : ^lane;
    end
  end
`endif

endmodule

// File: tb/tb_test_byte_mux.sv
// Self-checking bench for test_byte_mux: directed cases plus randomized vectors
// against a shift-based reference model.
module tb_test_byte_mux;

  logic        i_clk;
  logic        i_rst_n;
  logic [63:0] i_data;
  logic [3:0]  i_sel;
  logic [7:0]  o_data;
  logic        o_sel_err;
`ifdef TEST_BYTE_MUX_PARITY_EN
  logic        o_parity;
`endif

  int vectors;
  int miscompares;

  test_byte_mux dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_sel     (i_sel),
    .o_data    (o_data),
    .o_sel_err (o_sel_err)
`ifdef TEST_BYTE_MUX_PARITY_EN
    ,
    .o_parity  (o_parity)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_data(input logic [63:0] d, input int s);
    if (s >= 8) return 8'h00;
    return 8'((d >> (8 * s)) & 64'hFF);
  endfunction

  function automatic logic ref_err(input int s);
    return s >= 8;
  endfunction

  function automatic logic ref_parity(input logic [63:0] d, input int s);
    return 1'($countones(ref_data(d, s)) % 2);
  endfunction

  // Apply one vector, let one edge pass, then compare against the model.
  task automatic step(input string tag, input logic [63:0] d, input logic [3:0] s);
    i_data = d;
    i_sel  = s;
    @(posedge i_clk);
    #1;
    check({tag, ".data"}, o_data, ref_data(d, int'(s)));
    check({tag, ".err"}, 8'(o_sel_err), 8'(ref_err(int'(s))));
`ifdef TEST_BYTE_MUX_PARITY_EN
    check({tag, ".par"}, 8'(o_parity), 8'(ref_parity(d, int'(s))));
`endif
  endtask

  localparam logic [63:0] PAT = 64'hABCD_EFAB_CDEF_ABCD;

  initial begin
    logic [7:0] sweep_exp [8];
    sweep_exp = '{8'hCD, 8'hAB, 8'hEF, 8'hCD, 8'hAB, 8'hEF, 8'hCD, 8'hAB};
    vectors     = 0;
    miscompares = 0;

    // Reset held: outputs cleared immediately and across edges.
    i_rst_n = 1'b0;
    i_data  = PAT;
    i_sel   = 4'd3;
    #1;
    check("rst_now.data", o_data, 8'h00);
    check("rst_now.err", 8'(o_sel_err), 8'h00);
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_hold.data", o_data, 8'h00);
    check("rst_hold.err", 8'(o_sel_err), 8'h00);
`ifdef TEST_BYTE_MUX_PARITY_EN
    check("rst_hold.par", 8'(o_parity), 8'h00);
`endif
    i_rst_n = 1'b1;

    // Sweep all lanes, also against fixed expectations.
    for (int s = 0; s < 8; s++) begin
      step("sweep", PAT, 4'(s));
      check("sweep.const", o_data, sweep_exp[s]);
    end

    // Out of range, no wrap-around, then recovery.
    step("oor8", PAT, 4'd8);
    check("oor8.err1", 8'(o_sel_err), 8'h01);
    step("oor15", PAT, 4'd15);
    check("oor15.data0", o_data, 8'h00);
    step("recover", PAT, 4'd2);
    check("recover.ef", o_data, 8'hEF);

    // Async reset between edges.
    step("pre_rst", PAT, 4'd1);
    check("pre_rst.ab", o_data, 8'hAB);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst.data", o_data, 8'h00);
    check("async_rst.err", 8'(o_sel_err), 8'h00);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("post_rst.ab", o_data, 8'hAB);

    // Data change with constant select: exactly one cycle of lag.
    step("dchg0", PAT, 4'd7);
    check("dchg0.ab", o_data, 8'hAB);
    i_data = 64'h1200_0000_0000_0000;
    #2;
    check("dchg.lag", o_data, 8'hAB);
    @(posedge i_clk);
    #1;
    check("dchg1.12", o_data, 8'h12);
`ifdef TEST_BYTE_MUX_PARITY_EN
    check("par.12", 8'(o_parity), 8'h00);
    step("par_ab", PAT, 4'd1);
    check("par.ab", 8'(o_parity), 8'h01);
    step("par_cd", PAT, 4'd0);
    check("par.cd", 8'(o_parity), 8'h01);
`endif

    // Randomized vectors, roughly half out of range.
    for (int n = 0; n < 300; n++) begin
      step("rand", {32'($urandom), 32'($urandom)}, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
